// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the Minisys1A multiply/divide unit.
//   - XLEN_DEF / ITER_DEF : default operand width and iteration count
//   - md_op_e             : md_op encodings presented by the EXE stage
//   - md_state_e          : controller states
// ---------------------------------------------------------------------------
package md_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ITER_DEF = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101,
        MD_MFHI  = 3'b110,
        MD_MFLO  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// ---------------------------------------------------------------------------
// md_iter_core
// Iterative datapath for the multiply/divide unit. One bit per step.
//   i_clk, i_clrn          : clock, asynchronous active-low reset
//   i_start                : latch magnitudes of the operands and sign flags
//   i_step                 : perform one shift-add / shift-subtract iteration
//   i_fix                  : commit the sign-corrected result into the register
//   i_isDiv, i_isSigned    : operation class of the operands being latched
//   i_srcA, i_srcB         : rs / rt operands
//   o_resHi, o_resLo       : sign-corrected {HI, LO} result (combinational)
// ---------------------------------------------------------------------------
module md_iter_core
    import md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_clrn,
    input  logic            i_start,
    input  logic            i_step,
    input  logic            i_fix,
    input  logic            i_isDiv,
    input  logic            i_isSigned,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    output logic [XLEN-1:0] o_resHi,
    output logic [XLEN-1:0] o_resLo
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opB;
    logic              r_signA;
    logic              r_signB;
    logic              r_isDiv;

    logic [XLEN-1:0]   w_absA;
    logic [XLEN-1:0]   w_absB;
    logic [XLEN:0]     w_mulSum;
    logic [2*XLEN-1:0] w_mulNext;
    logic [XLEN:0]     w_shUpper;
    logic [XLEN:0]     w_trial;
    logic              w_qBit;
    logic [XLEN-1:0]   w_remNext;
    logic [2*XLEN-1:0] w_divNext;
    logic [2*XLEN-1:0] w_prodFix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_quotFix;
    logic [XLEN-1:0]   w_remFix;
    logic [2*XLEN-1:0] w_fixed;

    // The iteration always works on magnitudes; signs are reapplied in FIX.
    assign w_absA = (i_isSigned && i_srcA[XLEN-1]) ? -i_srcA : i_srcA;
    assign w_absB = (i_isSigned && i_srcB[XLEN-1]) ? -i_srcB : i_srcB;

    // Shift-add: the multiplier sits in the low half and is consumed LSB
    // first while the partial product grows into the high half.
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opB} : '0);
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

    // Restoring division on {rem, quot}: shift left, trial-subtract the
    // divisor, keep the difference only when it did not go negative.
    assign w_shUpper = r_acc[2*XLEN-1:XLEN-1];
    assign w_trial   = w_shUpper - {1'b0, r_opB};
    assign w_qBit    = ~w_trial[XLEN];
    assign w_remNext = w_qBit ? w_trial[XLEN-1:0] : w_shUpper[XLEN-1:0];
    assign w_divNext = {w_remNext, r_acc[XLEN-2:0], w_qBit};

    // Sign correction: product and quotient follow sign_a^sign_b, the
    // remainder follows the dividend.
    assign w_prodFix = (r_signA ^ r_signB) ? -r_acc : r_acc;
    assign w_quot    = r_acc[XLEN-1:0];
    assign w_rem     = r_acc[2*XLEN-1:XLEN];
    assign w_quotFix = (r_signA ^ r_signB) ? -w_quot : w_quot;
    assign w_remFix  = r_signA ? -w_rem : w_rem;
    assign w_fixed   = r_isDiv ? {w_remFix, w_quotFix} : w_prodFix;

    assign o_resHi = w_fixed[2*XLEN-1:XLEN];
    assign o_resLo = w_fixed[XLEN-1:0];

    // Operand latch and per-cycle iteration register.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_acc   <= '0;
            r_opB   <= '0;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_isDiv <= 1'b0;
        end else if (i_start) begin
            r_acc   <= {{XLEN{1'b0}}, (i_isDiv ? w_absA : w_absB)};
            r_opB   <= i_isDiv ? w_absB : w_absA;
            r_signA <= i_isSigned & i_srcA[XLEN-1];
            r_signB <= i_isSigned & i_srcB[XLEN-1];
            r_isDiv <= i_isDiv;
        end else if (i_step) begin
            r_acc <= r_isDiv ? w_divNext : w_mulNext;
        end else if (i_fix) begin
            r_acc <= w_fixed;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// ---------------------------------------------------------------------------
// md_ctrl
// Multiply/divide controller for the Minisys1A EXE stage. Owns HI/LO,
// sequences md_iter_core and stalls the pipeline while a result is pending.
//   i_clk, i_clrn     : clock, asynchronous active-low reset
//   i_md_valid        : EXE holds a valid md-class instruction
//   i_md_op           : md_op_e encoding
//   i_src_a, i_src_b  : rs / rt operands
//   i_flush           : pipeline flush, aborts an in-flight operation
//   o_md_pause        : stall request (combinational)
//   o_busy            : iteration in progress
//   o_md_rdata        : mfhi/mflo read data
//   o_hi, o_lo        : HI / LO registers
//   o_div_zero        : one-cycle pulse on divide by zero
// ---------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic            i_clk,
    input  logic            i_clrn,
    input  logic            i_md_valid,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_md_pause,
    output logic            o_busy,
    output logic [XLEN-1:0] o_md_rdata,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_div_zero
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e        r_state;
    md_state_e        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [XLEN-1:0]  r_hi;
    logic [XLEN-1:0]  r_lo;
    logic [XLEN-1:0]  r_rdata;
    logic             r_divZero;

    md_op_e           w_op;
    logic             w_busy;
    logic             w_issue;
    logic             w_isMulDiv;
    logic             w_isDiv;
    logic             w_isSigned;
    logic             w_divZero;
    logic             w_start;
    logic             w_step;
    logic             w_fix;
    logic [XLEN-1:0]  w_rdata;
    logic [XLEN-1:0]  w_resHi;
    logic [XLEN-1:0]  w_resLo;

    assign w_op       = md_op_e'(i_md_op);
    assign w_busy     = (r_state != ST_IDLE);
    // A stalled instruction simply re-presents and is taken here once idle.
    assign w_issue    = i_md_valid & ~i_flush & ~w_busy;
    assign w_isMulDiv = ~i_md_op[2];
    assign w_isDiv    = (w_op == MD_DIV) || (w_op == MD_DIVU);
    assign w_isSigned = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_divZero  = w_issue & w_isDiv & (i_src_b == '0);
    assign w_start    = w_issue & w_isMulDiv & ~w_divZero;

    md_iter_core #(.XLEN(XLEN)) u_core (
        .i_clk      (i_clk),
        .i_clrn     (i_clrn),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_fix      (w_fix),
        .i_isDiv    (w_isDiv),
        .i_isSigned (w_isSigned),
        .i_srcA     (i_src_a),
        .i_srcB     (i_src_b),
        .o_resHi    (w_resHi),
        .o_resLo    (w_resLo)
    );

    // Next-state logic: flush aborts CALC/FIX without touching HI/LO.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_step      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_stateNext = ST_CALC;
                    w_cntNext   = '0;
                end
            end
            ST_CALC: begin
                if (i_flush) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(ITER - 1)) begin
                        w_stateNext = ST_FIX;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                w_stateNext = ST_IDLE;
                w_fix       = ~i_flush;
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // mfhi/mflo read data is combinational on the accepting cycle and
    // otherwise holds whatever was last returned.
    always_comb begin
        w_rdata = r_rdata;
        if (w_issue && (w_op == MD_MFHI)) begin
            w_rdata = r_hi;
        end else if (w_issue && (w_op == MD_MFLO)) begin
            w_rdata = r_lo;
        end
    end

    // State register and iteration counter.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // HI/LO update from FIX or mthi/mtlo, read-data hold, div-zero pulse.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_rdata   <= '0;
            r_divZero <= 1'b0;
        end else begin
            r_rdata   <= w_rdata;
            r_divZero <= w_divZero;
            if (w_fix) begin
                r_hi <= w_resHi;
                r_lo <= w_resLo;
            end else if (w_issue) begin
                if (w_op == MD_MTHI) r_hi <= i_src_a;
                if (w_op == MD_MTLO) r_lo <= i_src_a;
            end
        end
    end

    assign o_md_pause = i_md_valid & w_busy & ~i_flush;
    assign o_busy     = w_busy;
    assign o_md_rdata = w_rdata;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_div_zero = r_divZero;

endmodule
